vc_tdm_sched2_sec: RTL

- Two-domain time-division scheduler with per-domain buffering. Sits directly upstream of vc_Mux2_sec and produces its sel.
- Domain 0 and domain 1 each own a private 1-entry message buffer.
- A free-running slot timer alternates ownership of the shared output between the two domains.
- Neither domain's traffic, stall or occupancy can change the timing seen by the other domain. This is the non-interference property the secure mux relies on.

---
 rtl/vc_tdm_sched2_sec_pkg.sv | 20 ++
 rtl/vc_sec_slot_timer.sv | 33 +++
 rtl/vc_tdm_sched2_sec.sv | 80 ++++++++
 3 files changed

// File: rtl/vc_tdm_sched2_sec_pkg.sv
// Shared definitions for the secure two-domain TDM blocks: domain labels and
// the ceiling-log2 helper used to size slot counters.
package vc_tdm_sched2_sec_pkg;

  localparam logic VC_SEC_DOM0 = 1'b0;
  localparam logic VC_SEC_DOM1 = 1'b1;

  function automatic int vc_clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vc_sec_slot_timer.sv
// Free-running slot timer: slot flips every p_slot_len cycles regardless of
// any traffic, so slot timing carries no information from either domain.
module vc_sec_slot_timer
  import vc_tdm_sched2_sec_pkg::*;
#(
  parameter int p_slot_len = 4
) (
  input  logic clk,
  input  logic reset,
  output logic slot,
  output logic last_cycle
);

  localparam int CW = (vc_clog2(p_slot_len) < 1) ? 1 : vc_clog2(p_slot_len);
  localparam logic [CW-1:0] LAST = CW'(p_slot_len - 1);

  logic [CW-1:0] cnt;

  assign last_cycle = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      slot <= VC_SEC_DOM0;
    end else if (last_cycle) begin
      cnt  <= '0;
      slot <= ~slot;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vc_tdm_sched2_sec.sv
// Two-domain time-division scheduler with a private 1-entry buffer per domain;
// out_dom feeds the sel of the downstream secure mux.
module vc_tdm_sched2_sec
  import vc_tdm_sched2_sec_pkg::*;
#(
  parameter int p_nbits    = 32,
  parameter int p_slot_len = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in0_val,
  output logic               in0_rdy,
  input  logic [p_nbits-1:0] in0_msg,
  input  logic               in1_val,
  output logic               in1_rdy,
  input  logic [p_nbits-1:0] in1_msg,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg,
  output logic               out_dom
);

  logic               slot;
  logic               last_cycle;
  logic [1:0]         in_val;
  logic [1:0]         in_rdy;
  logic [1:0]         full;
  logic [p_nbits-1:0] in_msg [2];
  logic [p_nbits-1:0] bufm   [2];

  vc_sec_slot_timer #(
    .p_slot_len (p_slot_len)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .slot       (slot),
    .last_cycle (last_cycle)
  );

  assign in_val    = {in1_val, in0_val};
  assign in_msg[0] = in0_msg;
  assign in_msg[1] = in1_msg;
  assign in0_rdy   = in_rdy[0];
  assign in1_rdy   = in_rdy[1];

  // Each domain's ready looks only at its own buffer and, in its own slot, out_rdy.
  for (genvar d = 0; d < 2; d++) begin : g_dom
    logic               own;
    logic               enq;
    logic               deq;
    logic               full_q;
    logic [p_nbits-1:0] buf_q;

    assign own       = (slot == ((d == 0) ? VC_SEC_DOM0 : VC_SEC_DOM1));
    assign deq       = own & full_q & out_rdy;
    assign in_rdy[d] = ~full_q | (own & out_rdy);
    assign enq       = in_val[d] & in_rdy[d];
    assign full[d]   = full_q;
    assign bufm[d]   = buf_q;

    always_ff @(posedge clk) begin
      if (reset)    full_q <= 1'b0;
      else if (enq) full_q <= 1'b1;
      else if (deq) full_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (enq) buf_q <= in_msg[d];
    end
  end

  assign out_dom = slot;
  assign out_val = (slot == VC_SEC_DOM1) ? full[1] : full[0];
  assign out_msg = (slot == VC_SEC_DOM1) ? bufm[1] : bufm[0];

  // Slot may only change on the timer's final count.
  a_slot_stable : assert property (@(posedge clk) disable iff (reset)
    !last_cycle |=> $stable(slot));

endmodule
